conf_reg_target: RTL and testbench
==================================

// Module: conf_reg_target
// PURPOSE
//  Responder end of the CONF valid/ready configuration channel. Accepts (c_addr, c_data) write
//  beats from the configuration initiator, buffers them in an in-order queue, and commits them
//  into a local register bank when apply_en permits. Provides registered read-back and an
//  error counter for out-of-range writes. Sits between the CONF initiator and datapath consumers.
// PARAMETERS
//  C_ADDR_WIDTH  8      address width, from CONF_item_pack
//  C_DATA_WIDTH  32     data width, from CONF_item_pack
//  NUM_REGS      16     implemented registers, addresses 0..NUM_REGS-1
//  DEPTH         4      write-queue entries, >=2
//  RESET_VAL     '0     reset value of every register
// PORTS
//  clk       in   1              clock, all logic on posedge
//  rst       in   1              synchronous reset, active-high
//  c_addr    in   C_ADDR_WIDTH   write address from initiator
//  c_data    in   C_DATA_WIDTH   write data from initiator
//  c_valid   in   1              initiator beat valid
//  c_ready   out  1              target can accept a beat
//  apply_en  in   1              1 = queue may drain into registers this cycle
//  rd_addr   in   C_ADDR_WIDTH   read-back address
//  rd_data   out  C_DATA_WIDTH   registered read-back data
//  q_level   out  $clog2(DEPTH+1) current queue occupancy
//  err_cnt   out  8              saturating count of out-of-range commits
// BEHAVIOUR
//  - Reset (rst=1 at posedge): queue empty, q_level=0, all regs=RESET_VAL, rd_data=0, err_cnt=0.
//    c_ready=0 while rst=1. Reset mid-burst drops all queued, uncommitted beats.
//  - c_ready = !rst && (q_level != DEPTH). Depends only on rst and state; never on c_valid/apply_en.
//  - Transfer: c_valid && c_ready at posedge -> beat pushed to queue tail. Beats with c_valid=1 and
//    c_ready=0 are not accepted; the initiator holds them (no drop, no duplicate).
//  - Drain: apply_en && q_level!=0 at posedge -> head popped. If addr<NUM_REGS, regs[addr]<=data;
//    else no reg write and err_cnt+1, saturating at 255.
//  - Push and pop on the same edge: q_level unchanged. Full with pop: no push that edge (c_ready
//    was already 0), push is possible from the next edge.
//  - Commit order = acceptance order; repeated writes to one address: last write wins.
//  - Latency: beat accepted at edge N with apply_en=1 -> committed at edge N+1 -> visible on
//    rd_data at edge N+2 (rd_addr held). Minimum one cycle in queue, no bypass.
//  - Throughput: 1 beat/cycle sustained when apply_en=1 continuously.
//  - rd_data <= (rd_addr<NUM_REGS) ? regs[rd_addr] : '0 each edge. Read and commit to the same
//    address on one edge return the old value.
//  - apply_en=0: queue fills to DEPTH, then c_ready=0 until apply_en returns.
// STRUCTURE
//  - CONF_item_pack: C_ADDR_WIDTH, C_DATA_WIDTH, new typedef conf_wr_t {addr, data}.
//  - Sub-module conf_sync_fifo #(type T=conf_wr_t, DEPTH): push/pop/full/empty/level, with
//    circular read/write pointers and wrap-around. Register bank, commit and err_cnt are in the top.
// TESTING
//  1 Reset: after rst, every rd_addr 0..15 -> rd_data=0, c_ready=1, q_level=0, err_cnt=0.
//  2 Single write addr=3 data=0xDEADBEEF, apply_en=1 -> rd_data@3 = 0xDEADBEEF at edge N+2,
//    not earlier.
//  3 apply_en=0, 6 back-to-back beats -> 4 accepted, c_ready=0, q_level=4. Raise apply_en ->
//    all 6 beats committed in order, none lost or duplicated.
//  4 Writes addr=5 data=1, then 2, then 3, back-to-back -> final rd_data@5 = 3.
//  5 Writes to addr=16 and 255 -> err_cnt=2, no reg changes. 300 bad writes -> err_cnt=255.
//  6 Queue holds 3 beats, rst pulsed for 1 cycle -> q_level=0, regs=RESET_VAL, beats not committed.

Source files
------------

// File: rtl/conf_reg_target_pkg.sv
// Shared CONF channel item definition: address/data widths, the write-beat
// struct carried through the queue, and a saturating counter helper.
package conf_reg_target_pkg;

    localparam int C_ADDR_WIDTH = 8;
    localparam int C_DATA_WIDTH = 32;

    typedef struct packed {
        logic [C_ADDR_WIDTH-1:0] addr;
        logic [C_DATA_WIDTH-1:0] data;
    } conf_wr_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/conf_sync_fifo.sv
// In-order write queue with circular read/write pointers. Push is ignored
// while full and pop is ignored while empty, so callers may request freely.
module conf_sync_fifo
    import conf_reg_target_pkg::*;
#(
    parameter type T      = conf_wr_t,
    parameter int  DEPTH  = 4,
    localparam int PW     = $clog2(DEPTH),
    localparam int LW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              pop_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic          w_do_push;
    logic          w_do_pop;
    logic [PW-1:0] w_wr_next;
    logic [PW-1:0] w_rd_next;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == LW'(0));
    assign level     = r_level;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wr_next = (r_wr_ptr == PW'(DEPTH - 1)) ? PW'(0) : r_wr_ptr + PW'(1);
    assign w_rd_next = (r_rd_ptr == PW'(DEPTH - 1)) ? PW'(0) : r_rd_ptr + PW'(1);

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= PW'(0);
            r_rd_ptr <= PW'(0);
            r_level  <= LW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/conf_reg_target.sv
// Responder end of the CONF configuration channel: queues accepted write
// beats, commits them into a local register bank when apply_en allows.
module conf_reg_target
    import conf_reg_target_pkg::*;
#(
    parameter int                      NUM_REGS  = 16,
    parameter int                      DEPTH     = 4,
    parameter logic [C_DATA_WIDTH-1:0] RESET_VAL = '0,
    localparam int                     LW        = $clog2(DEPTH + 1),
    localparam int                     IW        = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_ADDR_WIDTH-1:0] c_addr,
    input  logic [C_DATA_WIDTH-1:0] c_data,
    input  logic                    c_valid,
    output logic                    c_ready,
    input  logic                    apply_en,
    input  logic [C_ADDR_WIDTH-1:0] rd_addr,
    output logic [C_DATA_WIDTH-1:0] rd_data,
    output logic [LW-1:0]           q_level,
    output logic [7:0]              err_cnt
);

    logic [C_DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [C_DATA_WIDTH-1:0] r_rd_data;
    logic [7:0]              r_err_cnt;

    conf_wr_t                w_push_item;
    conf_wr_t                w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_head_in_range;
    logic                    w_rd_in_range;

    assign w_push_item     = '{addr: c_addr, data: c_data};
    // c_ready looks only at reset and occupancy, never at c_valid or apply_en.
    assign c_ready         = !rst && !w_full;
    assign w_push          = c_valid && c_ready;
    assign w_pop           = apply_en && !w_empty;
    assign w_head_in_range = (w_head.addr < C_ADDR_WIDTH'(NUM_REGS));
    assign w_rd_in_range   = (rd_addr < C_ADDR_WIDTH'(NUM_REGS));

    conf_sync_fifo #(
        .T     (conf_wr_t),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_item),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (q_level)
    );

    // Register bank: commit the queue head when it addresses an implemented register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_pop && w_head_in_range) begin
            r_regs[w_head.addr[IW-1:0]] <= w_head.data;
        end
    end

    // Registered read-back; samples pre-commit contents on a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_regs[rd_addr[IW-1:0]];
        end else begin
            r_rd_data <= '0;
        end
    end

    // Saturating count of commits that fell outside the register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_pop && !w_head_in_range) begin
            r_err_cnt <= sat_inc8(r_err_cnt);
        end
    end

    assign rd_data = r_rd_data;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_conf_reg_target.sv
// Directed self-checking bench for conf_reg_target: reset, latency,
// back-pressure, ordering, out-of-range handling and mid-burst reset.
module tb_conf_reg_target;

    logic        clk;
    logic        rst;
    logic [7:0]  c_addr;
    logic [31:0] c_data;
    logic        c_valid;
    logic        c_ready;
    logic        apply_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [2:0]  q_level;
    logic [7:0]  err_cnt;

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_regs [16];

    conf_reg_target dut (
        .clk      (clk),
        .rst      (rst),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_valid  (c_valid),
        .c_ready  (c_ready),
        .apply_en (apply_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .q_level  (q_level),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_checks++;
        if (c_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", c_ready);
        else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (c_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", c_ready);
        else n_pass++;
        n_checks++;
        if (q_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", q_level);
        else n_pass++;
        n_checks++;
        if (err_cnt !== 8'd0) $display("FAIL reset_err: got %0d want 0", err_cnt);
        else n_pass++;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 8'(a);
            tick();
            n_checks++;
            if (rd_data !== 32'd0) $display("FAIL reset_reg%0d: got %h want 0", a, rd_data);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        apply_en = 1'b1;
        rd_addr  = 8'd3;
        c_addr   = 8'd3;
        c_data   = 32'hDEAD_BEEF;
        c_valid  = 1'b1;
        tick();
        c_valid = 1'b0;
        n_checks++;
        if (q_level !== 3'd1) $display("FAIL single_level_n: got %0d want 1", q_level);
        else n_pass++;
        n_checks++;
        if (rd_data !== 32'd0) $display("FAIL single_rd_n: got %h want 0", rd_data);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_data !== 32'd0) $display("FAIL single_rd_n1: got %h want 0", rd_data);
        else n_pass++;
        n_checks++;
        if (q_level !== 3'd0) $display("FAIL single_level_n1: got %0d want 0", q_level);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_data !== 32'hDEAD_BEEF) $display("FAIL single_rd_n2: got %h want deadbeef", rd_data);
        else n_pass++;
        exp_regs[3] = 32'hDEAD_BEEF;
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [6];
        int         sent;
        int         budget;
        logic       acc;
        addrs    = '{8'd6, 8'd7, 8'd8, 8'd6, 8'd7, 8'd9};
        sent     = 0;
        apply_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            c_addr  = addrs[sent];
            c_data  = 32'hA000_0000 + 32'(sent);
            c_valid = 1'b1;
            acc     = c_ready;
            tick();
            if (acc) sent++;
        end
        n_checks++;
        if (sent !== 4) $display("FAIL b2b_accepted: got %0d want 4", sent);
        else n_pass++;
        n_checks++;
        if (c_ready !== 1'b0) $display("FAIL b2b_ready_full: got %b want 0", c_ready);
        else n_pass++;
        n_checks++;
        if (q_level !== 3'd4) $display("FAIL b2b_level_full: got %0d want 4", q_level);
        else n_pass++;
        apply_en = 1'b1;
        budget   = 0;
        while (sent < 6 && budget < 20) begin
            c_addr  = addrs[sent];
            c_data  = 32'hA000_0000 + 32'(sent);
            c_valid = 1'b1;
            acc     = c_ready;
            tick();
            if (acc) sent++;
            budget++;
        end
        c_valid = 1'b0;
        n_checks++;
        if (sent !== 6) $display("FAIL b2b_all_sent: got %0d want 6", sent);
        else n_pass++;
        budget = 0;
        while (q_level != 3'd0 && budget < 20) begin
            tick();
            budget++;
        end
        n_checks++;
        if (q_level !== 3'd0) $display("FAIL b2b_drain: got %0d want 0", q_level);
        else n_pass++;
        exp_regs[6] = 32'hA000_0003;
        exp_regs[7] = 32'hA000_0004;
        exp_regs[8] = 32'hA000_0002;
        exp_regs[9] = 32'hA000_0005;
        for (int a = 6; a < 10; a++) begin
            rd_addr = 8'(a);
            tick();
            n_checks++;
            if (rd_data !== exp_regs[a]) $display("FAIL b2b_reg%0d: got %h want %h", a, rd_data, exp_regs[a]);
            else n_pass++;
        end
        n_checks++;
        if (err_cnt !== 8'd0) $display("FAIL b2b_err: got %0d want 0", err_cnt);
        else n_pass++;
    endtask

    task automatic test_last_wins();
        apply_en = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            c_addr  = 8'd5;
            c_data  = 32'(v);
            c_valid = 1'b1;
            n_checks++;
            if (c_ready !== 1'b1) $display("FAIL lastwins_ready%0d: got %b want 1", v, c_ready);
            else n_pass++;
            tick();
        end
        c_valid = 1'b0;
        n_checks++;
        if (q_level !== 3'd1) $display("FAIL lastwins_level: got %0d want 1", q_level);
        else n_pass++;
        tick();
        rd_addr = 8'd5;
        tick();
        exp_regs[5] = 32'd3;
        n_checks++;
        if (rd_data !== 32'd3) $display("FAIL lastwins_reg5: got %h want 3", rd_data);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        apply_en = 1'b1;
        c_valid  = 1'b1;
        c_addr   = 8'd16;
        c_data   = 32'h1111_1111;
        tick();
        c_addr   = 8'd255;
        c_data   = 32'h2222_2222;
        tick();
        c_valid  = 1'b0;
        tick();
        tick();
        n_checks++;
        if (err_cnt !== 8'd2) $display("FAIL oor_err2: got %0d want 2", err_cnt);
        else n_pass++;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 8'(a);
            tick();
            n_checks++;
            if (rd_data !== exp_regs[a]) $display("FAIL oor_reg%0d: got %h want %h", a, rd_data, exp_regs[a]);
            else n_pass++;
        end
        rd_addr = 8'd16;
        tick();
        n_checks++;
        if (rd_data !== 32'd0) $display("FAIL oor_rd16: got %h want 0", rd_data);
        else n_pass++;
        c_valid = 1'b1;
        c_addr  = 8'd200;
        c_data  = 32'h3333_3333;
        for (int k = 0; k < 300; k++) tick();
        c_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (err_cnt !== 8'd255) $display("FAIL oor_saturate: got %0d want 255", err_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_en = 1'b0;
        c_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            c_addr = 8'(k);
            c_data = 32'h5555_0000 + 32'(k + 1);
            tick();
        end
        c_valid = 1'b0;
        n_checks++;
        if (q_level !== 3'd3) $display("FAIL midrst_level_before: got %0d want 3", q_level);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if (c_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", c_ready);
        else n_pass++;
        n_checks++;
        if (q_level !== 3'd0) $display("FAIL midrst_level: got %0d want 0", q_level);
        else n_pass++;
        rst      = 1'b0;
        apply_en = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (err_cnt !== 8'd0) $display("FAIL midrst_err: got %0d want 0", err_cnt);
        else n_pass++;
        for (int a = 0; a < 6; a++) begin
            rd_addr = 8'(a);
            tick();
            n_checks++;
            if (rd_data !== 32'd0) $display("FAIL midrst_reg%0d: got %h want 0", a, rd_data);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int a = 0; a < 16; a++) exp_regs[a] = 32'd0;
        rst      = 1'b1;
        c_addr   = 8'd0;
        c_data   = 32'd0;
        c_valid  = 1'b0;
        apply_en = 1'b0;
        rd_addr  = 8'd0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_last_wins();
        test_out_of_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
